cpu_6502c: RTL and testbench

- Reduced 6502C-compatible CPU core: the top-level CPU block of the Atari system model.
- Fetches and executes a defined subset of 6502 opcodes over a 16-bit address bus and a bidirectional 8-bit data bus.
- Keeps the 6502 cycle counts per opcode, so the cycle-count bench (opcode on DB, wait N cycles) holds.
- One CPU cycle per rising edge of phi0_in.

---
 rtl/cpu_6502c.sv | 185 ++++++++++++++++++
 tb/tb_cpu_6502c.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cpu_6502c.sv
// Reduced 6502C core: reset-vector fetch plus a small opcode subset with
// 6502 cycle counts, one CPU cycle per rising edge of phi0_in.
module cpu_6502c #(
  parameter logic [15:0] RESET_VECTOR_LO = 16'hFFFC
) (
  input  logic        phi0_in,
  input  logic        RES,
  input  logic        RDY,
  input  logic        IRQ_L,
  input  logic        NMI_L,
  input  logic        SO,
  inout  wire  [7:0]  DB,
  output logic [15:0] AB,
  output logic        RW,
  output logic        SYNC,
  output logic        phi1_out,
  output logic        phi2_out
);

  typedef enum logic [2:0] {RST0, RST1, T0, T1, T2, T3} state_t;

  state_t      state, state_n;
  logic [7:0]  a, x, y, sp, p, ir, adl, dout;
  logic [7:0]  a_n, x_n, y_n, p_n, ir_n, adl_n, dout_n;
  logic [15:0] pc, pc_n, ab_n;
  logic        rw_n, sync_n;
  logic        so_q, stall, so_fall, imm, done;
  logic [1:0]  int_unused;
  logic        unused_sink;
  logic [8:0]  sum, diff;

  assign phi1_out    = ~phi0_in;
  assign phi2_out    = phi0_in;
  assign DB          = RW ? 8'hzz : dout;
  assign stall       = ~RDY & RW;
  assign so_fall     = so_q & ~SO;
  assign sum         = {1'b0, a} + {1'b0, DB} + {8'd0, p[0]};
  assign diff        = {1'b0, a} - {1'b0, DB};
  assign unused_sink = ^{int_unused, sp};

  function automatic logic [7:0] set_nz(input logic [7:0] flags, input logic [7:0] v);
    set_nz = {v[7], flags[6:2], (v == 8'h00), flags[0]};
  endfunction

  // Next-state and bus decode; 'done' means the next cycle is an opcode fetch.
  always_comb begin
    state_n = state;
    a_n     = a;
    x_n     = x;
    y_n     = y;
    p_n     = p;
    ir_n    = ir;
    adl_n   = adl;
    dout_n  = dout;
    pc_n    = pc;
    ab_n    = AB;
    rw_n    = RW;
    sync_n  = SYNC;
    imm     = 1'b0;
    done    = 1'b0;
    case (state)
      RST0: begin
        pc_n    = {pc[15:8], DB};
        ab_n    = RESET_VECTOR_LO + 16'd1;
        state_n = RST1;
      end
      RST1: begin
        pc_n = {DB, pc[7:0]};
        done = 1'b1;
      end
      T0: begin
        ir_n    = DB;
        pc_n    = pc + 16'd1;
        ab_n    = pc + 16'd1;
        sync_n  = 1'b0;
        state_n = T1;
      end
      T1: begin
        done = 1'b1;
        case (ir)
          8'hA9: begin a_n = DB; p_n = set_nz(p, DB); imm = 1'b1; end
          8'hA2: begin x_n = DB; p_n = set_nz(p, DB); imm = 1'b1; end
          8'hA0: begin y_n = DB; p_n = set_nz(p, DB); imm = 1'b1; end
          8'h69: begin
            a_n    = sum[7:0];
            p_n    = set_nz(p, sum[7:0]);
            p_n[6] = (a[7] == DB[7]) && (sum[7] != a[7]);
            p_n[0] = sum[8];
            imm    = 1'b1;
          end
          8'h29: begin a_n = a & DB; p_n = set_nz(p, a & DB); imm = 1'b1; end
          8'h09: begin a_n = a | DB; p_n = set_nz(p, a | DB); imm = 1'b1; end
          8'h49: begin a_n = a ^ DB; p_n = set_nz(p, a ^ DB); imm = 1'b1; end
          8'hC9: begin p_n = set_nz(p, diff[7:0]); p_n[0] = ~diff[8]; imm = 1'b1; end
          8'hE8: begin x_n = x + 8'd1; p_n = set_nz(p, x + 8'd1); end
          8'hC8: begin y_n = y + 8'd1; p_n = set_nz(p, y + 8'd1); end
          8'hCA: begin x_n = x - 8'd1; p_n = set_nz(p, x - 8'd1); end
          8'h88: begin y_n = y - 8'd1; p_n = set_nz(p, y - 8'd1); end
          8'hAA: begin x_n = a; p_n = set_nz(p, a); end
          8'h8A: begin a_n = x; p_n = set_nz(p, x); end
          8'hA8: begin y_n = a; p_n = set_nz(p, a); end
          8'h98: begin a_n = y; p_n = set_nz(p, y); end
          8'h18: p_n[0] = 1'b0;
          8'h38: p_n[0] = 1'b1;
          8'h4C, 8'hAD, 8'h8D: begin
            adl_n   = DB;
            pc_n    = pc + 16'd1;
            ab_n    = pc + 16'd1;
            state_n = T2;
            done    = 1'b0;
          end
          default: ;
        endcase
        if (imm) pc_n = pc + 16'd1;
      end
      T2: begin
        if (ir == 8'h4C) begin
          pc_n = {DB, adl};
          done = 1'b1;
        end else begin
          ab_n    = {DB, adl};
          pc_n    = pc + 16'd1;
          state_n = T3;
          if (ir == 8'h8D) begin
            rw_n   = 1'b0;
            dout_n = a;
          end
        end
      end
      T3: begin
        if (ir == 8'hAD) begin
          a_n = DB;
          p_n = set_nz(p, DB);
        end
        done = 1'b1;
      end
      default: done = 1'b1;
    endcase
    if (done) begin
      ab_n    = pc_n;
      rw_n    = 1'b1;
      sync_n  = 1'b1;
      state_n = T0;
    end
    // SO wins over any V value computed by ADC in the same cycle.
    if (so_fall) p_n[6] = 1'b1;
  end

  // A stalled read cycle freezes everything except the SO edge detector.
  always_ff @(posedge phi0_in) begin
    so_q       <= SO;
    int_unused <= {IRQ_L, NMI_L};
    if (RES) begin
      a     <= 8'h00;
      x     <= 8'h00;
      y     <= 8'h00;
      sp    <= 8'hFD;
      p     <= 8'h34;
      pc    <= 16'h0000;
      ir    <= 8'hEA;
      adl   <= 8'h00;
      dout  <= 8'h00;
      state <= RST0;
      AB    <= RESET_VECTOR_LO;
      RW    <= 1'b1;
      SYNC  <= 1'b0;
    end else if (stall) begin
      if (so_fall) p[6] <= 1'b1;
    end else begin
      a     <= a_n;
      x     <= x_n;
      y     <= y_n;
      p     <= p_n;
      pc    <= pc_n;
      ir    <= ir_n;
      adl   <= adl_n;
      dout  <= dout_n;
      state <= state_n;
      AB    <= ab_n;
      RW    <= rw_n;
      SYNC  <= sync_n;
    end
  end

endmodule

// File: tb/tb_cpu_6502c.sv
// Scoreboard bench for cpu_6502c: a directed program in a bus memory model,
// with hand-computed per-cycle bus and register expectations.
module tb_cpu_6502c;

  logic        phi0_in = 1'b0;
  logic        RES, RDY, IRQ_L, NMI_L, SO;
  wire  [7:0]  DB;
  logic [15:0] AB;
  logic        RW, SYNC, phi1_out, phi2_out;

  logic [7:0] mem [0:65535];

  typedef struct {
    int          cyc;
    logic [15:0] ab;
    logic        rw;
    logic        sync;
    logic        chk_db;
    logic [7:0]  db;
    logic        chk_regs;
    logic [7:0]  a, x, y, p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   mon_cyc = 0;
  bit   running = 1'b0;

  localparam logic [7:0] PROG_MAIN [33] = '{
    8'hA9, 8'h00, 8'hA9, 8'h80, 8'hA9, 8'h5A, 8'h8D, 8'h34, 8'h12, 8'h18,
    8'hA9, 8'h7F, 8'h69, 8'h01, 8'h38, 8'hA9, 8'hFF, 8'h69, 8'h00, 8'hAD,
    8'h34, 8'h12, 8'hA2, 8'hFF, 8'hE8, 8'hFF, 8'hC9, 8'h60, 8'hA8, 8'hCA,
    8'h4C, 8'h00, 8'hC0};
  localparam logic [7:0] PROG_HIGH [7] = '{
    8'h29, 8'h0F, 8'h49, 8'hFF, 8'hAA, 8'hEA, 8'hEA};

  cpu_6502c dut (
    .phi0_in (phi0_in),
    .RES     (RES),
    .RDY     (RDY),
    .IRQ_L   (IRQ_L),
    .NMI_L   (NMI_L),
    .SO      (SO),
    .DB      (DB),
    .AB      (AB),
    .RW      (RW),
    .SYNC    (SYNC),
    .phi1_out(phi1_out),
    .phi2_out(phi2_out)
  );

  always #5 phi0_in = ~phi0_in;

  assign DB = RW ? mem[AB] : 8'hzz;

  always @(posedge phi0_in) if (!RW) mem[AB] <= DB;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp, input int cyc);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  task automatic checkOutput(input exp_t e);
    check("ab", AB, e.ab, e.cyc);
    check("rw", {15'b0, RW}, {15'b0, e.rw}, e.cyc);
    check("sync", {15'b0, SYNC}, {15'b0, e.sync}, e.cyc);
    if (e.chk_db) check("db", {8'h00, DB}, {8'h00, e.db}, e.cyc);
    if (e.chk_regs) begin
      check("reg_a", {8'h00, dut.a}, {8'h00, e.a}, e.cyc);
      check("reg_x", {8'h00, dut.x}, {8'h00, e.x}, e.cyc);
      check("reg_y", {8'h00, dut.y}, {8'h00, e.y}, e.cyc);
      check("reg_p", {8'h00, dut.p}, {8'h00, e.p}, e.cyc);
      check("reg_s", {8'h00, dut.sp}, 16'h00FD, e.cyc);
    end
  endtask

  task automatic push(input int cyc, input logic [15:0] ab, input logic rw,
                      input logic sync, input logic chk_db, input logic [7:0] db,
                      input logic chk_regs, input logic [7:0] ea, input logic [7:0] ex,
                      input logic [7:0] ey, input logic [7:0] ep);
    exp_t e;
    e.cyc = cyc; e.ab = ab; e.rw = rw; e.sync = sync; e.chk_db = chk_db; e.db = db;
    e.chk_regs = chk_regs; e.a = ea; e.x = ex; e.y = ey; e.p = ep;
    exp_q.push_back(e);
  endtask

  task automatic sync_at(input int cyc, input logic [15:0] ab, input logic [7:0] ea,
                         input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ep);
    push(cyc, ab, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, ea, ex, ey, ep);
  endtask

  task automatic bus_at(input int cyc, input logic [15:0] ab, input logic rw);
    push(cyc, ab, rw, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    for (int i = 0; i < 33; i++) mem[16'h8000 + i] = PROG_MAIN[i];
    for (int i = 0; i < 7; i++)  mem[16'hC000 + i] = PROG_HIGH[i];

    push(0, 16'hFFFC, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h34);
    bus_at(1, 16'hFFFD, 1'b1);
    sync_at(2,  16'h8000, 8'h00, 8'h00, 8'h00, 8'h34);
    sync_at(4,  16'h8002, 8'h00, 8'h00, 8'h00, 8'h36);
    sync_at(6,  16'h8004, 8'h80, 8'h00, 8'h00, 8'hB4);
    sync_at(8,  16'h8006, 8'h5A, 8'h00, 8'h00, 8'h34);
    push(11, 16'h1234, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    push(12, 16'h8009, 1'b1, 1'b1, 1'b1, 8'h18, 1'b1, 8'h5A, 8'h00, 8'h00, 8'h34);
    sync_at(14, 16'h800A, 8'h5A, 8'h00, 8'h00, 8'h34);
    sync_at(16, 16'h800C, 8'h7F, 8'h00, 8'h00, 8'h34);
    sync_at(18, 16'h800E, 8'h80, 8'h00, 8'h00, 8'hF4);
    sync_at(20, 16'h800F, 8'h80, 8'h00, 8'h00, 8'hF5);
    sync_at(22, 16'h8011, 8'hFF, 8'h00, 8'h00, 8'hF5);
    sync_at(24, 16'h8013, 8'h00, 8'h00, 8'h00, 8'h37);
    bus_at(27, 16'h1234, 1'b1);
    sync_at(28, 16'h8016, 8'h5A, 8'h00, 8'h00, 8'h35);
    sync_at(30, 16'h8018, 8'h5A, 8'hFF, 8'h00, 8'hB5);
    sync_at(32, 16'h8019, 8'h5A, 8'h00, 8'h00, 8'h37);
    sync_at(34, 16'h801A, 8'h5A, 8'h00, 8'h00, 8'h37);
    sync_at(36, 16'h801C, 8'h5A, 8'h00, 8'h00, 8'hB4);
    sync_at(38, 16'h801D, 8'h5A, 8'h00, 8'h5A, 8'h34);
    sync_at(40, 16'h801E, 8'h5A, 8'hFF, 8'h5A, 8'hB4);
    for (int c = 41; c <= 44; c++) bus_at(c, 16'h801F, 1'b1);
    bus_at(45, 16'h8020, 1'b1);
    sync_at(46, 16'hC000, 8'h5A, 8'hFF, 8'h5A, 8'hB4);
    sync_at(48, 16'hC002, 8'h0A, 8'hFF, 8'h5A, 8'h34);
    sync_at(50, 16'hC004, 8'hF5, 8'hFF, 8'h5A, 8'hB4);
    sync_at(52, 16'hC005, 8'hF5, 8'hF5, 8'h5A, 8'hB4);
    sync_at(54, 16'hC006, 8'hF5, 8'hF5, 8'h5A, 8'hB4);
  endtask

  // Monitor: pops the entry scheduled for this cycle, otherwise SYNC must be low.
  always @(negedge phi0_in) begin
    if (running) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == mon_cyc) begin
        checkOutput(exp_q.pop_front());
      end else begin
        check("idle_sync", {15'b0, SYNC}, 16'h0000, mon_cyc);
      end
      mon_cyc++;
    end
  end

  initial begin
    RES = 1'b1; RDY = 1'b1; IRQ_L = 1'b1; NMI_L = 1'b1; SO = 1'b1;
    applyStimulus();
    repeat (2) @(posedge phi0_in);
    #1;
    RES = 1'b0;
    running = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      RDY = (c >= 41 && c <= 43) ? 1'b0 : 1'b1;
      @(posedge phi0_in);
      #1;
    end
    running = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL timeout: got %0d pending entries expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
